// File: rtl/countdown_timer_ctrl_pkg.sv
// Shared definitions for the countdown timer controller: state encodings,
// the done-LED pattern and a counter-width helper.
package countdown_timer_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  localparam int LED_W = 15;
  localparam logic [LED_W-1:0] DONE_PATTERN = 15'h7FFF;

  // Divider counters need at least one bit even for DIV == 1.
  function automatic int cnt_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/countdown_timer_ctrl_tick_gen.sv
// Modulo-DIV enable divider: counts 0..DIV-1 while en is high and flags the
// wrap cycle on pulse; clr forces the count back to zero.
module countdown_timer_ctrl_tick_gen
  import countdown_timer_ctrl_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic pulse
);

  localparam int W = cnt_width(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         at_last_s;

  assign at_last_s = (cnt_q == LAST);

  // Next count: clear wins, otherwise advance and wrap only while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {W{1'b0}};
    end else if (en) begin
      if (at_last_s) begin
        cnt_d = {W{1'b0}};
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign pulse = en & ~clr & at_last_s;

endmodule

// File: rtl/countdown_timer_ctrl.sv
// RUN/PAUSE/DONE sequencer for the BCD down-counter: derives the count tick,
// digit-scan select and done-LED blink from one-cycle button pulses.
module countdown_timer_ctrl
  import countdown_timer_ctrl_pkg::*;
#(
  parameter int TICK_DIV  = 100_000_000,
  parameter int SCAN_BITS = 17,
  parameter int BLINK_DIV = 50_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_start,
  input  logic             btn_clear,
  input  logic             cnt_zero,
  output logic             tick,
  output logic             cnt_stop,
  output logic             cnt_load,
  output logic [1:0]       clk_ctl,
  output logic [LED_W-1:0] done_led,
  output logic [1:0]       state_dbg
);

  state_e               state_q, state_d;
  logic                 tick_q, tick_d;
  logic                 stop_q, stop_d;
  logic                 load_q, load_d;
  logic [LED_W-1:0]     led_q, led_d;
  logic [SCAN_BITS-1:0] scan_q;

  logic pre_en_s, pre_clr_s, pre_pulse_s;
  logic blink_en_s, blink_clr_s, blink_pulse_s;

  countdown_timer_ctrl_tick_gen #(.DIV(TICK_DIV)) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .en    (pre_en_s),
    .clr   (pre_clr_s),
    .pulse (pre_pulse_s)
  );

  // The blink divider restarts from zero every time DONE is entered.
  assign blink_en_s  = (state_q == ST_DONE) & ~btn_clear;
  assign blink_clr_s = ~blink_en_s;

  countdown_timer_ctrl_tick_gen #(.DIV(BLINK_DIV)) u_blink (
    .clk   (clk),
    .rst   (rst),
    .en    (blink_en_s),
    .clr   (blink_clr_s),
    .pulse (blink_pulse_s)
  );

  // Next state and registered-output values; clear beats zero beats start.
  always_comb begin
    state_d   = state_q;
    pre_en_s  = 1'b0;
    pre_clr_s = 1'b0;
    load_d    = 1'b0;
    if (btn_clear) begin
      state_d   = ST_IDLE;
      pre_clr_s = 1'b1;
      load_d    = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (btn_start) begin
            state_d   = ST_RUN;
            pre_clr_s = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        // The prescaler only advances on RUN cycles with no event, so a
        // pause keeps the partial second intact.
        ST_RUN: begin
          if (cnt_zero) begin
            state_d = ST_DONE;
          end else if (btn_start) begin
            state_d = ST_PAUSE;
          end else begin
            pre_en_s = 1'b1;
          end
        end
        ST_PAUSE: begin
          if (btn_start) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_PAUSE;
          end
        end
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end

    tick_d = pre_pulse_s;
    stop_d = (state_d != ST_RUN);

    if (btn_clear) begin
      led_d = {LED_W{1'b0}};
    end else if (state_d == ST_DONE) begin
      if (state_q != ST_DONE) begin
        led_d = DONE_PATTERN;
      end else if (blink_pulse_s) begin
        led_d = ~led_q;
      end else begin
        led_d = led_q;
      end
    end else begin
      led_d = {LED_W{1'b0}};
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tick_q  <= 1'b0;
      stop_q  <= 1'b1;
      load_q  <= 1'b0;
      led_q   <= {LED_W{1'b0}};
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      stop_q  <= stop_d;
      load_q  <= load_d;
      led_q   <= led_d;
    end
  end

  // Free-running digit-scan counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_q <= {SCAN_BITS{1'b0}};
    end else begin
      scan_q <= scan_q + SCAN_BITS'(1);
    end
  end

  assign tick      = tick_q;
  assign cnt_stop  = stop_q;
  assign cnt_load  = load_q;
  assign done_led  = led_q;
  assign state_dbg = state_q;
  assign clk_ctl   = scan_q[SCAN_BITS-1:SCAN_BITS-2];

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Scoreboard bench: a cycle-level reference model predicts every output word,
// and a separate monitor compares the DUT against the queued predictions.
module tb_countdown_timer_ctrl;

  localparam int TD = 4;
  localparam int BD = 3;
  localparam int SB = 4;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

  typedef struct packed {
    logic        tick;
    logic        stop;
    logic        load;
    logic [1:0]  ctl;
    logic [14:0] led;
    logic [1:0]  st;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_start = 1'b0;
  logic        btn_clear = 1'b0;
  logic        cnt_zero = 1'b0;
  logic        tick, cnt_stop, cnt_load;
  logic [1:0]  clk_ctl, state_dbg;
  logic [14:0] done_led;

  countdown_timer_ctrl #(.TICK_DIV(TD), .SCAN_BITS(SB), .BLINK_DIV(BD)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_start (btn_start),
    .btn_clear (btn_clear),
    .cnt_zero  (cnt_zero),
    .tick      (tick),
    .cnt_stop  (cnt_stop),
    .cnt_load  (cnt_load),
    .clk_ctl   (clk_ctl),
    .done_led  (done_led),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  obs_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: state name, cycles of the current second already run,
  // cycles spent in DONE, cycles since reset release.
  int m_state   = S_IDLE;
  int m_elapsed = 0;
  int m_done    = 0;
  int m_cycles  = 0;

  function automatic obs_t sample();
    obs_t a;
    a.tick = tick; a.stop = cnt_stop; a.load = cnt_load;
    a.ctl = clk_ctl; a.led = done_led; a.st = state_dbg;
    return a;
  endfunction

  task automatic compare(input string name, input obs_t act, input obs_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got tick=%b stop=%b load=%b ctl=%0d led=%h st=%0d, expected tick=%b stop=%b load=%b ctl=%0d led=%h st=%0d",
               name, $time, act.tick, act.stop, act.load, act.ctl, act.led, act.st,
               exp.tick, exp.stop, exp.load, exp.ctl, exp.led, exp.st);
    end
  endtask

  task automatic check_reset(input string name);
    obs_t e;
    e.tick = 1'b0; e.stop = 1'b1; e.load = 1'b0;
    e.ctl = 2'd0; e.led = 15'h0; e.st = 2'd0;
    compare(name, sample(), e);
  endtask

  // Drive one cycle of inputs, predict the outputs after the next edge.
  task automatic step(input logic clr, input logic start, input logic zero);
    obs_t e;
    int   ns;
    btn_clear = clr; btn_start = start; cnt_zero = zero;
    e.tick = 1'b0; e.load = 1'b0;
    ns = m_state;
    if (clr) begin
      ns = S_IDLE; e.load = 1'b1; m_elapsed = 0;
    end else begin
      case (m_state)
        S_IDLE: if (start) begin ns = S_RUN; m_elapsed = 0; end
        S_RUN: begin
          if (zero) begin
            ns = S_DONE; m_done = 0;
          end else if (start) begin
            ns = S_PAUSE;
          end else begin
            if (m_elapsed % TD == TD - 1) e.tick = 1'b1;
            m_elapsed++;
          end
        end
        S_PAUSE: if (start) ns = S_RUN;
        default: m_done++;
      endcase
    end
    m_state  = ns;
    m_cycles++;
    e.stop = (ns != S_RUN);
    e.ctl  = 2'((m_cycles >> (SB - 2)) % 4);
    e.led  = (ns == S_DONE && ((m_done / BD) % 2) == 0) ? 15'h7FFF : 15'h0000;
    e.st   = 2'(ns);
    q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic model_reset();
    m_state = S_IDLE; m_elapsed = 0; m_done = 0; m_cycles = 0;
  endtask

  // Monitor: outputs are presented every cycle; compare just after each edge.
  initial begin
    obs_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        compare("outputs", sample(), e);
      end
    end
  end

  initial begin
    @(posedge clk); #1;
    check_reset("reset_values");
    @(posedge clk); #2;
    rst = 1'b0;
    model_reset();

    // Start, then free-run long enough for several ticks.
    step(1'b0, 1'b1, 1'b0);
    repeat (13) step(1'b0, 1'b0, 1'b0);

    // Pause with the prescaler at 2, hold, then resume.
    for (int k = 0; k < 2 * TD && (m_elapsed % TD) != 2; k++) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    repeat (10) step(1'b0, 1'b0, $urandom_range(0, 1) == 0);
    step(1'b0, 1'b1, 1'b0);
    repeat (6) step(1'b0, 1'b0, 1'b0);

    // Zero arriving on the wrap cycle: no tick, straight to DONE; start ignored.
    for (int k = 0; k < 2 * TD && (m_elapsed % TD) != TD - 1; k++) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 14; k++) step(1'b0, k % 4 == 1, $urandom_range(0, 1) == 0);

    // Clear out of DONE, zero lingering in IDLE, then clear+start in PAUSE.
    step(1'b1, 1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    repeat (2) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    repeat (4) step(1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of RUN.
    step(1'b0, 1'b1, 1'b0);
    repeat (5) step(1'b0, 1'b0, 1'b0);
    rst = 1'b1; btn_start = 1'b0; btn_clear = 1'b0; cnt_zero = 1'b0;
    #1;
    check_reset("async_reset_mid_run");
    @(posedge clk); #1;
    check_reset("reset_held");
    #1;
    rst = 1'b0;
    model_reset();

    // Randomised traffic across all states.
    for (int k = 0; k < 2500; k++) begin
      step($urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 24) == 0);
    end

    repeat (2) @(posedge clk);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got %0d pending, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
